// File: rtl/seg_scan_display.sv
// Time-multiplexed seven-segment driver: one shared hex decoder, a per-digit scan slot
// with an anti-ghost blank window, and a per-frame shadow of the displayed value.
module seg_scan_display #(
    parameter int DIGITS      = 4,
    parameter int SCAN_DIV    = 12000,
    parameter int BLANK       = 16,
    parameter bit SEG_ACT_LOW = 1'b0,
    parameter bit DIG_ACT_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [4*DIGITS-1:0]   data_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  blank_lz,
    output logic [7:0]            seg_led,
    output logic [DIGITS-1:0]     dig_sel,
    output logic                  frame_tick
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CW-1:0]     CNT_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0]     CNT_BLANK = CW'(BLANK);
    localparam logic [IW-1:0]     IDX_LAST  = IW'(DIGITS - 1);
    localparam logic [7:0]        SEG_OFF   = {8{SEG_ACT_LOW}};
    localparam logic [DIGITS-1:0] DIG_OFF   = {DIGITS{DIG_ACT_LOW}};

    logic [CW-1:0]         cnt;
    logic [IW-1:0]         idx;
    logic [4*DIGITS-1:0]   sh_data;
    logic [DIGITS-1:0]     sh_dp;

    logic [DIGITS-1:0]     lz_zero;
    logic                  lz_run;
    logic [3:0]            cur_nib;
    logic [6:0]            glyph;
    logic [7:0]            seg_next;
    logic [DIGITS-1:0]     dig_next;

    // lz_zero[i] is set when nibble i and every nibble above it are zero.
    always_comb begin
        lz_zero = '0;
        lz_run  = 1'b1;
        for (int unsigned j = 0; j < DIGITS; j++) begin
            lz_run = lz_run & (sh_data[4*(DIGITS-1-j) +: 4] == 4'h0);
            lz_zero[DIGITS-1-j] = lz_run;
        end
    end

    always_comb begin
        cur_nib = 4'(sh_data >> {idx, 2'b00});
        case (cur_nib)
            4'h0:    glyph = 7'h3f;
            4'h1:    glyph = 7'h06;
            4'h2:    glyph = 7'h5b;
            4'h3:    glyph = 7'h4f;
            4'h4:    glyph = 7'h66;
            4'h5:    glyph = 7'h6d;
            4'h6:    glyph = 7'h7d;
            4'h7:    glyph = 7'h07;
            4'h8:    glyph = 7'h7f;
            4'h9:    glyph = 7'h6f;
            4'hA:    glyph = 7'h77;
            4'hB:    glyph = 7'h7c;
            4'hC:    glyph = 7'h39;
            4'hD:    glyph = 7'h5e;
            4'hE:    glyph = 7'h79;
            default: glyph = 7'h71;
        endcase
        if (blank_lz && (idx != '0) && lz_zero[idx])
            glyph = '0;
        seg_next = {sh_dp[idx], glyph};
        dig_next = DIGITS'(1) << idx;
    end

    // XOR with the "off" pattern applies the output polarity in the register stage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt        <= '0;
            idx        <= '0;
            sh_data    <= '0;
            sh_dp      <= '0;
            frame_tick <= 1'b0;
            seg_led    <= SEG_OFF;
            dig_sel    <= DIG_OFF;
        end else if (!en) begin
            cnt        <= '0;
            idx        <= '0;
            sh_data    <= data_in;
            sh_dp      <= dp_in;
            frame_tick <= 1'b0;
            seg_led    <= SEG_OFF;
            dig_sel    <= DIG_OFF;
        end else begin
            if (cnt < CNT_BLANK) begin
                seg_led <= SEG_OFF;
                dig_sel <= DIG_OFF;
            end else begin
                seg_led <= seg_next ^ SEG_OFF;
                dig_sel <= dig_next ^ DIG_OFF;
            end

            frame_tick <= 1'b0;
            if (cnt == CNT_LAST) begin
                cnt <= '0;
                if (idx == IDX_LAST) begin
                    idx        <= '0;
                    sh_data    <= data_in;
                    sh_dp      <= dp_in;
                    frame_tick <= 1'b1;
                end else begin
                    idx <= idx + 1'b1;
                end
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_display.sv
// Bench for seg_scan_display: directed phases plus random stimulus, checked every cycle
// against a frame-position model of the scan and a per-frame shadow of the inputs.
module tb_seg_scan_display;

    localparam int DIGITS   = 4;
    localparam int SCAN_DIV = 8;
    localparam int BLANK    = 2;
    localparam int FRAME    = DIGITS * SCAN_DIV;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [15:0] data_in;
    logic [3:0]  dp_in;
    logic        blank_lz;
    logic [7:0]  seg_led;
    logic [3:0]  dig_sel;
    logic        frame_tick;

    int total = 0;
    int bad   = 0;

    // Model state: enabled edges since scan start, and the value the display is showing.
    int          k = 0;
    logic [15:0] m_data = '0;
    logic [3:0]  m_dp   = '0;
    logic [6:0]  seg_tab [16];

    seg_scan_display #(
        .DIGITS(DIGITS),
        .SCAN_DIV(SCAN_DIV),
        .BLANK(BLANK),
        .SEG_ACT_LOW(1'b0),
        .DIG_ACT_LOW(1'b1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .en(en),
        .data_in(data_in),
        .dp_in(dp_in),
        .blank_lz(blank_lz),
        .seg_led(seg_led),
        .dig_sel(dig_sel),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    task automatic tick(input string tag);
        logic [7:0]  e_seg;
        logic [3:0]  e_dig;
        logic        e_ft;
        logic [15:0] high;
        logic        lz;
        int p, d, w;
        e_seg = 8'h00;
        e_dig = 4'hF;
        e_ft  = 1'b0;
        if (!rst_n) begin
            k = 0;
            m_data = '0;
            m_dp = '0;
        end else if (!en) begin
            k = 0;
            m_data = data_in;
            m_dp = dp_in;
        end else begin
            k++;
            p = (k - 1) % FRAME;
            d = p / SCAN_DIV;
            w = p % SCAN_DIV;
            if (w >= BLANK) begin
                high  = m_data >> (4 * d);
                lz    = blank_lz && (d > 0) && (high == 16'h0);
                e_dig = ~(4'b0001 << d);
                e_seg = {m_dp[d], lz ? 7'h00 : seg_tab[high[3:0]]};
            end
            if (k % FRAME == 0) begin
                e_ft = 1'b1;
                m_data = data_in;
                m_dp = dp_in;
            end
        end
        @(posedge clk);
        #1;
        total++;
        assert (seg_led === e_seg) else begin
            bad++;
            $error("FAIL %s seg_led k=%0d observed=%h expected=%h", tag, k, seg_led, e_seg);
        end
        total++;
        assert (dig_sel === e_dig) else begin
            bad++;
            $error("FAIL %s dig_sel k=%0d observed=%b expected=%b", tag, k, dig_sel, e_dig);
        end
        total++;
        assert (frame_tick === e_ft) else begin
            bad++;
            $error("FAIL %s frame_tick k=%0d observed=%b expected=%b", tag, k, frame_tick, e_ft);
        end
    endtask

    task automatic run(input int n, input string tag);
        for (int i = 0; i < n; i++) tick(tag);
    endtask

    initial begin
        seg_tab = '{7'h3f, 7'h06, 7'h5b, 7'h4f, 7'h66, 7'h6d, 7'h7d, 7'h07,
                    7'h7f, 7'h6f, 7'h77, 7'h7c, 7'h39, 7'h5e, 7'h79, 7'h71};
        rst_n    = 1'b0;
        en       = 1'b1;
        data_in  = 16'($urandom);
        dp_in    = 4'($urandom);
        blank_lz = 1'b0;
        #2;

        run(3, "reset");

        // Basic scan, shadow loaded while disabled.
        rst_n   = 1'b1;
        en      = 1'b0;
        data_in = 16'h1234;
        dp_in   = 4'b0100;
        run(2, "load_idle");
        en = 1'b1;
        run(3, "first_slot");
        total++;
        assert (dig_sel === 4'b1110 && seg_led === 8'h66) else begin
            bad++;
            $error("FAIL first_digit observed=%b/%h expected=1110/66", dig_sel, seg_led);
        end
        run(2 * FRAME, "basic");

        // Hex letters.
        en      = 1'b0;
        data_in = 16'hABCD;
        dp_in   = 4'b0000;
        tick("hex_load");
        en = 1'b1;
        run(FRAME + 4, "hex");

        // Leading-zero blanking cases.
        en       = 1'b0;
        blank_lz = 1'b1;
        data_in  = 16'h0070;
        tick("lz_load");
        en = 1'b1;
        run(FRAME, "lz_0070");
        data_in = 16'h0000;
        run(2 * FRAME, "lz_0000");
        blank_lz = 1'b0;
        data_in  = 16'h0070;
        run(2 * FRAME, "nolz_0070");

        // Tear-free update during the digit-1 slot.
        en      = 1'b0;
        data_in = 16'h1111;
        dp_in   = 4'($urandom);
        tick("tear_load");
        en = 1'b1;
        run(10, "tear_pre");
        data_in = 16'h2222;
        run(2 * FRAME, "tear");

        // Reset for one edge during digit 2.
        en = 1'b0;
        tick("rst_sync");
        en = 1'b1;
        run(18, "rst_pre");
        rst_n = 1'b0;
        tick("rst_mid");
        rst_n = 1'b1;
        run(FRAME + 8, "rst_post");

        // Enable dropped for 5 cycles with changing data.
        run(13, "en_pre");
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            data_in = 16'($urandom);
            dp_in   = 4'($urandom);
            tick("en_low");
        end
        en = 1'b1;
        data_in = 16'($urandom);
        run(FRAME + 8, "en_post");

        // Random phase: sparse input changes so whole frames are observed.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 15) == 0)
                data_in = 16'($urandom) >> (4 * $urandom_range(0, 4));
            if ($urandom_range(0, 15) == 0)
                dp_in = 4'($urandom);
            if ($urandom_range(0, 31) == 0)
                blank_lz = ~blank_lz;
            en    = ($urandom_range(0, 63) != 0);
            rst_n = ($urandom_range(0, 127) != 0);
            tick("random");
        end
        rst_n = 1'b1;
        en    = 1'b1;
        run(FRAME, "tail");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
